// File: rtl/ysyx_22050612_mem_arbiter.sv
// Shares one memory port between IFU (master 0) and LSU (master 1), one transaction in flight.
// Define ARB_ROUND_ROBIN_EN to break request ties round-robin instead of fixed LSU priority.
module ysyx_22050612_mem_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic        OWN_IFU = 1'b0;
  localparam logic        OWN_LSU = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic              owner;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              grant_ifu;
  logic              grant_lsu;
  logic              handshake;
  logic              timeout_hit;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_grant;
`endif

  // Grant: LSU by default; on a tie the round-robin build favours the master not served last.
  always_comb begin
    grant_lsu = lsu_req_valid;
    grant_ifu = ifu_req_valid & ~lsu_req_valid;
`ifdef ARB_ROUND_ROBIN_EN
    if (ifu_req_valid && lsu_req_valid) begin
      grant_lsu = (last_grant == OWN_IFU);
      grant_ifu = (last_grant == OWN_LSU);
    end
`endif
  end

  assign handshake   = (state == IDLE) && !rst && (grant_ifu || grant_lsu);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (handshake) state_next = ISSUE;
      ISSUE: if (mem_req_ready) state_next = WAIT;
      WAIT:  if (mem_rsp_valid || timeout_hit) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst) begin
          ifu_req_ready = grant_ifu;
          lsu_req_ready = grant_lsu;
        end
      end
      ISSUE: mem_req_valid = 1'b1;
      RESP: begin
        ifu_rsp_valid = (owner == OWN_IFU);
        lsu_rsp_valid = (owner == OWN_LSU);
      end
      default: ;
    endcase
  end

  assign ifu_rdata   = rdata_q;
  assign lsu_rdata   = rdata_q;
  assign ifu_rsp_err = err_q;
  assign lsu_rsp_err = err_q;

  // Request latch, watchdog counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_IFU;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (handshake) begin
            if (grant_lsu) begin
              owner     <= OWN_LSU;
              mem_addr  <= lsu_addr;
              mem_wen   <= lsu_wen;
              mem_wdata <= lsu_wdata;
              mem_wmask <= lsu_wmask;
            end else begin
              owner     <= OWN_IFU;
              mem_addr  <= ifu_addr;
              mem_wen   <= 1'b0;
              mem_wdata <= '0;
              mem_wmask <= '0;
            end
          end
        end
        ISSUE: if (mem_req_ready) cnt <= '0;
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // A response on the expiry cycle takes precedence over the error.
          if (mem_rsp_valid) begin
            rdata_q <= mem_wen ? '0 : mem_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst)            last_grant <= OWN_LSU;
    else if (handshake) last_grant <= grant_lsu ? OWN_LSU : OWN_IFU;
  end
`endif

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Self-checking bench for ysyx_22050612_mem_arbiter: directed cases plus randomized contention
// against a cycle-count reference model derived from the arbitration and timeout rules.
module tb_ysyx_22050612_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int checks = 0;
  int errors = 0;

  // Pending request per master: index 0 = IFU, 1 = LSU
  logic [63:0] p_addr  [2];
  logic        p_wen   [2];
  logic [63:0] p_wdata [2];
  logic [7:0]  p_wmask [2];
`ifdef ARB_ROUND_ROBIN_EN
  bit last_lsu = 1'b1;
`endif

  ysyx_22050612_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Tie rule: fixed LSU priority, or the master not granted last in the round-robin build.
  function automatic bit pick_lsu(input bit iv, input bit lv);
`ifdef ARB_ROUND_ROBIN_EN
    if (iv && lv) return !last_lsu;
`else
    if (iv && lv) return 1'b1;
`endif
    return lv;
  endfunction

  task automatic set_req(input bit m, input logic [63:0] a, input bit w,
                         input logic [63:0] wd, input logic [7:0] wm);
    p_addr[m]  = a;
    p_wen[m]   = m ? w : 1'b0;
    p_wdata[m] = wd;
    p_wmask[m] = m ? wm : 8'h00;
  endtask

  task automatic drive(input bit m);
    if (m) begin
      lsu_req_valid = 1'b1;
      lsu_addr      = p_addr[1];
      lsu_wen       = p_wen[1];
      lsu_wdata     = p_wdata[1];
      lsu_wmask     = p_wmask[1];
    end else begin
      ifu_req_valid = 1'b1;
      ifu_addr      = p_addr[0];
    end
  endtask

  // Runs from just after the handshake edge up to the expected response pulse, acting as the memory.
  task automatic finish_txn(input bit m, input int rdy, input int k, input logic [63:0] rd);
    int exp_pulse, issue_seen, wcnt, pulse_at, pulses, stray;
    bit exp_err, acc, own, oth;
    logic [63:0] exp_rd;
    exp_err    = (k >= TO);
    exp_pulse  = (rdy + 1) + ((exp_err ? TO - 1 : k) + 1) + 1;
    exp_rd     = (exp_err || p_wen[m]) ? 64'h0 : rd;
    issue_seen = 0; wcnt = 0; pulse_at = -1; pulses = 0; stray = 0; acc = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_lsu = m;
`endif
    for (int c = 1; c <= exp_pulse; c++) begin
      @(negedge clk);
      if (m) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = acc && (wcnt == k);
      mem_rdata     = mem_rsp_valid ? rd : {32'($urandom), 32'($urandom)};
      if (acc) wcnt++;
      #1;
      if (mem_req_valid) begin
        issue_seen++;
        chk("mem_addr", mem_addr, p_addr[m]);
        chk("mem_wen", 64'(mem_wen), 64'(p_wen[m]));
        chk("mem_wmask", 64'(mem_wmask), 64'(p_wmask[m]));
        if (m) chk("mem_wdata", mem_wdata, p_wdata[m]);
        if (issue_seen == rdy + 1) mem_req_ready = 1'b1;
      end
      own = m ? lsu_rsp_valid : ifu_rsp_valid;
      oth = m ? ifu_rsp_valid : lsu_rsp_valid;
      if (own) begin
        pulses++;
        pulse_at = c;
        chk("rsp_rdata", m ? lsu_rdata : ifu_rdata, exp_rd);
        chk("rsp_err", 64'(m ? lsu_rsp_err : ifu_rsp_err), 64'(exp_err));
      end
      if (oth) stray++;
      if (mem_req_ready) acc = 1'b1;
    end
    mem_rsp_valid = 1'b0;
    chk("pulse_count", 64'(pulses), 64'd1);
    chk("pulse_cycle", 64'(pulse_at), 64'(exp_pulse));
    chk("issue_cycles", 64'(issue_seen), 64'(rdy + 1));
    chk("stray_pulse", 64'(stray), 64'd0);
  endtask

  task automatic arb_round(input bit iv, input bit lv, input int rdy, input int k,
                           input logic [63:0] rd, output bit won);
    @(negedge clk);
    if (iv) drive(1'b0);
    if (lv) drive(1'b1);
    #1;
    won = pick_lsu(iv, lv);
    chk("ifu_ready", 64'(ifu_req_ready), 64'(iv && !won));
    chk("lsu_ready", 64'(lsu_req_ready), 64'(lv && won));
    chk("rsp_idle", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    finish_txn(won, rdy, k, rd);
  endtask

  task automatic chk_reset_state();
    chk("rst_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
    chk("rst_rsp_valid", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    chk("rst_rsp_err", 64'({ifu_rsp_err, lsu_rsp_err}), 64'd0);
    chk("rst_ifu_rdata", ifu_rdata, 64'd0);
    chk("rst_lsu_rdata", lsu_rdata, 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
  endtask

  initial begin
    bit won, pi, pl;
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_state();
    @(negedge clk);
    rst = 1'b0;

    // Simultaneous requests, then the loser is served right after the winner's response
    set_req(1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h0);
    set_req(1'b1, 64'h8000_1000, 1'b0, 64'h0, 8'h0);
    arb_round(1'b1, 1'b1, 0, 0, 64'h1111_2222_3333_4444, won);
    arb_round(!won, won, 0, 0, 64'h5555_6666_7777_8888, won);

    // Single IFU fetch at minimum latency
    set_req(1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h0);
    arb_round(1'b1, 1'b0, 0, 0, 64'h0000_0013_0000_0297, won);

    // LSU write with memory ready held off for three cycles
    set_req(1'b1, 64'h8000_0008, 1'b1, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    arb_round(1'b0, 1'b1, 3, 1, 64'hFFFF_0000_FFFF_0000, won);

    // Memory never answers, then a normal request
    set_req(1'b0, 64'h8000_0010, 1'b0, 64'h0, 8'h0);
    arb_round(1'b1, 1'b0, 0, 100000, 64'h0, won);
    set_req(1'b1, 64'h8000_0018, 1'b0, 64'h0, 8'h0);
    arb_round(1'b0, 1'b1, 1, 2, 64'hCAFE_F00D_1234_5678, won);

    // Response exactly at expiry wins; one cycle later is an error
    set_req(1'b1, 64'h8000_0020, 1'b0, 64'h0, 8'h0);
    arb_round(1'b0, 1'b1, 0, TO - 1, 64'hA5A5_5A5A_0F0F_F0F0, won);
    set_req(1'b0, 64'h8000_0028, 1'b0, 64'h0, 8'h0);
    arb_round(1'b1, 1'b0, 2, TO, 64'h1234_1234_1234_1234, won);
    set_req(1'b0, 64'h8000_0030, 1'b0, 64'h0, 8'h0);
    arb_round(1'b1, 1'b0, 0, 3, 64'h0BAD_C0DE_0BAD_C0DE, won);

    // Reset during WAIT abandons the transaction; a late response is ignored
    set_req(1'b1, 64'h8000_0040, 1'b0, 64'h0, 8'h0);
    @(negedge clk); drive(1'b1); #1;
    chk("rstw_lsu_ready", 64'(lsu_req_ready), 64'd1);
    @(negedge clk); lsu_req_valid = 1'b0; #1;
    chk("rstw_issue", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clk); mem_req_ready = 1'b0; rst = 1'b1; #1;
    chk("rstw_wait", 64'(mem_req_valid), 64'd0);
    @(negedge clk); rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD; #1;
    chk_reset_state();
`ifdef ARB_ROUND_ROBIN_EN
    last_lsu = 1'b1;
`endif
    @(negedge clk); mem_rsp_valid = 1'b0; #1;
    chk("rstw_no_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    chk("rstw_no_issue", 64'(mem_req_valid), 64'd0);
    chk("rstw_rdata", lsu_rdata, 64'd0);

    // Tie right after reset, then randomized contention
    set_req(1'b0, 64'h8000_0100, 1'b0, 64'h0, 8'h0);
    set_req(1'b1, 64'h8000_1100, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0);
    arb_round(1'b1, 1'b1, 1, 1, 64'h7777_7777_7777_7777, won);
    arb_round(!won, won, 0, 1, 64'h8888_8888_8888_8888, won);

    pi = 1'b0; pl = 1'b0;
    for (int r = 0; r < 40; r++) begin
      if (!pi && $urandom_range(0, 3) != 0) begin
        set_req(1'b0, {32'($urandom), 32'($urandom)}, 1'b0, 64'h0, 8'h0);
        pi = 1'b1;
      end
      if (!pl && $urandom_range(0, 3) != 0) begin
        set_req(1'b1, {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)),
                {32'($urandom), 32'($urandom)}, 8'($urandom));
        pl = 1'b1;
      end
      if (!pi && !pl) begin
        set_req(1'b0, {32'($urandom), 32'($urandom)}, 1'b0, 64'h0, 8'h0);
        pi = 1'b1;
      end
      arb_round(pi, pl, int'($urandom_range(0, 3)), int'($urandom_range(0, 10)),
                {32'($urandom), 32'($urandom)}, won);
      if (won) pl = 1'b0; else pi = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
